// File: rtl/sweep_result_avg.sv
// Sweep result averager: accumulates 2^K sweeps of per-point magnitude/phase
// results in RAM and returns the running average on a registered readback port.
module sweep_result_avg #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int GUARD      = 8
) (
   input  logic                  dac_clk_i,
   input  logic                  dac_rst_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [3:0]            avg_log2_i,
   input  logic                  res_we_i,
   input  logic [ADDR_WIDTH-1:0] res_addr_i,
   input  logic [DATA_WIDTH-1:0] res_mag_i,
   input  logic [DATA_WIDTH-1:0] res_phs_i,
   input  logic                  sweep_done_i,
   input  logic [ADDR_WIDTH:0]   rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [8:0]            sweep_cnt_o,
   output logic                  ovr_o
);

   localparam int ACC_W = DATA_WIDTH + GUARD;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t                state;
   logic [3:0]            k;
   logic [3:0]            k_req;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  cnt_full;
   logic                  accept;
   logic                  stray;
   logic                  kill;

   logic [ACC_W-1:0]      mag_ram [DEPTH];
   logic [ACC_W-1:0]      phs_ram [DEPTH];

   // Stage 1: captured strobe plus the synchronous RAM read issued with it.
   logic                  p1_vld;
   logic [ADDR_WIDTH-1:0] p1_addr;
   logic [ACC_W-1:0]      p1_mag;
   logic [ACC_W-1:0]      p1_phs;
   logic [ACC_W-1:0]      rmw_mag;
   logic [ACC_W-1:0]      rmw_phs;
   // Stage 2: sum being written; stage 3: the write that landed last edge.
   logic                  p2_vld;
   logic [ADDR_WIDTH-1:0] p2_addr;
   logic [ACC_W-1:0]      p2_mag;
   logic [ACC_W-1:0]      p2_phs;
   logic                  p3_vld;
   logic [ADDR_WIDTH-1:0] p3_addr;
   logic [ACC_W-1:0]      p3_mag;
   logic [ACC_W-1:0]      p3_phs;

   logic [ACC_W-1:0]      base_mag;
   logic [ACC_W-1:0]      base_phs;
   logic [ACC_W-1:0]      sum_mag;
   logic [ACC_W-1:0]      sum_phs;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [ACC_W-1:0]      ram_wmag;
   logic [ACC_W-1:0]      ram_wphs;

   assign k_req    = (avg_log2_i > 4'd8) ? 4'd8 : avg_log2_i;
   assign cnt_full = (sweep_cnt_o == (9'd1 << k));
   // Once the last sweep has ended, later strobes belong to no sweep.
   assign accept   = res_we_i && (state == RUN) && !cnt_full;
   assign stray    = res_we_i && !accept;
   assign kill     = dac_rst_i || start_i || abort_i;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      base_mag = rmw_mag;
      base_phs = rmw_phs;
      if (p3_vld && (p3_addr == p1_addr)) begin
         base_mag = p3_mag;
         base_phs = p3_phs;
      end
      if (p2_vld && (p2_addr == p1_addr)) begin
         base_mag = p2_mag;
         base_phs = p2_phs;
      end
      sum_mag = base_mag + p1_mag;
      sum_phs = base_phs + p1_phs;

      ram_we    = 1'b0;
      ram_waddr = p2_addr;
      ram_wmag  = p2_mag;
      ram_wphs  = p2_phs;
      if (!kill && (state == CLEAR)) begin
         ram_we    = 1'b1;
         ram_waddr = clr_addr;
         ram_wmag  = '0;
         ram_wphs  = '0;
      end else if (!kill && p2_vld) begin
         ram_we = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         state       <= IDLE;
         k           <= '0;
         sweep_cnt_o <= '0;
         ovr_o       <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         clr_addr    <= '0;
      end else if (start_i) begin
         state       <= CLEAR;
         k           <= k_req;
         sweep_cnt_o <= '0;
         ovr_o       <= 1'b0;
         busy_o      <= 1'b1;
         done_o      <= 1'b0;
         clr_addr    <= '0;
      end else if (abort_i) begin
         state  <= IDLE;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         ovr_o  <= ovr_o || stray;
      end else begin
         ovr_o <= ovr_o || stray;
         case (state)
            IDLE: ;
            CLEAR: begin
               clr_addr <= clr_addr + ADDR_WIDTH'(1);
               if (clr_addr == '1) state <= RUN;
            end
            RUN: begin
               if (sweep_done_i && !cnt_full) sweep_cnt_o <= sweep_cnt_o + 9'd1;
               // Stage 2 commits on this same edge, so only stage 1 must drain.
               if (cnt_full && !p1_vld) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            DONE: ;
         endcase
      end
   end

   always_ff @(posedge dac_clk_i) begin
      if (kill) begin
         p1_vld <= 1'b0;
         p2_vld <= 1'b0;
         p3_vld <= 1'b0;
      end else begin
         p1_vld <= accept;
         p2_vld <= p1_vld;
         p3_vld <= p2_vld;
      end
   end

   // NOTE: RAM and pipeline data carry no reset; only the valids qualify them.
   always_ff @(posedge dac_clk_i) begin
      if (accept) begin
         p1_addr <= res_addr_i;
         p1_mag  <= {{GUARD{1'b0}}, res_mag_i};
         p1_phs  <= {{GUARD{res_phs_i[DATA_WIDTH-1]}}, res_phs_i};
      end
      rmw_mag <= mag_ram[res_addr_i];
      rmw_phs <= phs_ram[res_addr_i];
      p2_addr <= p1_addr;
      p2_mag  <= sum_mag;
      p2_phs  <= sum_phs;
      p3_addr <= p2_addr;
      p3_mag  <= p2_mag;
      p3_phs  <= p2_phs;
      if (ram_we) begin
         mag_ram[ram_waddr] <= ram_wmag;
         phs_ram[ram_waddr] <= ram_wphs;
      end
   end

   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         rd_data_o <= '0;
      end else if (rd_addr_i[ADDR_WIDTH]) begin
         rd_data_o <= DATA_WIDTH'($signed(phs_ram[rd_addr_i[ADDR_WIDTH-1:0]]) >>> k);
      end else begin
         rd_data_o <= DATA_WIDTH'(mag_ram[rd_addr_i[ADDR_WIDTH-1:0]] >> k);
      end
   end

endmodule

// File: tb/tb_sweep_result_avg.sv
// Bench for sweep_result_avg: directed runs checked against literals and a
// delayed-commit accumulator model compared on every falling edge.
module tb_sweep_result_avg;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [3:0]  avg;
   logic        res_we;
   logic [7:0]  res_addr;
   logic [31:0] res_mag;
   logic [31:0] res_phs;
   logic        sweep_done;
   logic [8:0]  rd_addr;
   logic        rd_chk;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic [8:0]  sweep_cnt;
   logic        ovr;

   int n_tests = 0;
   int n_fail  = 0;

   sweep_result_avg dut (
      .dac_clk_i   (clk),
      .dac_rst_i   (rst),
      .start_i     (start),
      .abort_i     (abort),
      .avg_log2_i  (avg),
      .res_we_i    (res_we),
      .res_addr_i  (res_addr),
      .res_mag_i   (res_mag),
      .res_phs_i   (res_phs),
      .sweep_done_i(sweep_done),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data),
      .busy_o      (busy),
      .done_o      (done),
      .sweep_cnt_o (sweep_cnt),
      .ovr_o       (ovr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: RAM contents as committed, plus strobes still in flight.
   typedef struct {
      int          addr;
      logic [39:0] mag;
      logic [39:0] phs;
      int          age;
   } wr_t;

   wr_t         pend[$];
   logic [39:0] m_mag [256];
   logic [39:0] m_phs [256];
   int          m_state = 0;
   int          m_cd    = 0;
   int          m_k     = 0;
   int          m_cnt   = 0;
   bit          m_ovr   = 0;
   bit          m_live  = 0;
   bit          m_rd_chk = 0;
   logic [31:0] m_rd_exp = '0;

   always @(posedge clk) begin
      logic [39:0] v;
      int          a;
      a = int'(rd_addr[7:0]);
      if (rd_addr[8]) v = $signed(m_phs[a]) >>> m_k;
      else            v = m_mag[a] >> m_k;
      m_rd_exp = v[31:0];
      m_rd_chk = rd_chk;
      if (rst) begin
         m_state = 0; m_k = 0; m_cnt = 0; m_ovr = 0; m_live = 1;
         m_rd_exp = '0; m_rd_chk = 1;
         pend.delete();
      end else if (start) begin
         m_k = (avg > 4'd8) ? 8 : int'(avg);
         m_cnt = 0; m_ovr = 0; m_state = 1; m_cd = 256;
         pend.delete();
      end else if (abort) begin
         if (res_we && !(m_state == 2 && m_cnt < (1 << m_k))) m_ovr = 1;
         m_state = 0;
         pend.delete();
      end else begin
         for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].age == 1) begin
               m_mag[pend[i].addr] = m_mag[pend[i].addr] + pend[i].mag;
               m_phs[pend[i].addr] = m_phs[pend[i].addr] + pend[i].phs;
               pend.delete(i);
            end else begin
               pend[i].age = pend[i].age + 1;
            end
         end
         case (m_state)
            1: begin
               if (res_we) m_ovr = 1;
               m_mag[256 - m_cd] = '0;
               m_phs[256 - m_cd] = '0;
               m_cd = m_cd - 1;
               if (m_cd == 0) m_state = 2;
            end
            2: begin
               if (res_we) begin
                  if (m_cnt < (1 << m_k))
                     pend.push_back('{int'(res_addr), {8'h00, res_mag}, {{8{res_phs[31]}}, res_phs}, 0});
                  else
                     m_ovr = 1;
               end
               if (sweep_done && m_cnt < (1 << m_k)) m_cnt = m_cnt + 1;
            end
            default: if (res_we) m_ovr = 1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("model_cnt", 64'(sweep_cnt), 64'(m_cnt));
         check("model_ovr", 64'(ovr), 64'(m_ovr));
         if (m_rd_chk) check("model_rd", 64'(rd_data), 64'(m_rd_exp));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_start(input logic [3:0] a);
      avg = a; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic strobe(input logic [7:0] a, input logic [31:0] m, input logic [31:0] p, input logic sd);
      res_we = 1'b1; res_addr = a; res_mag = m; res_phs = p; sweep_done = sd;
      tick();
      res_we = 1'b0; sweep_done = 1'b0;
   endtask

   task automatic sweep_end();
      sweep_done = 1'b1;
      tick();
      sweep_done = 1'b0;
   endtask

   task automatic rd_lit(input string name, input logic [8:0] a, input logic [31:0] exp);
      rd_addr = a; rd_chk = 1'b1;
      tick();
      check(name, 64'(rd_data), 64'(exp));
      rd_chk = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; avg = '0; res_we = 1'b0; res_addr = '0;
      res_mag = '0; res_phs = '0; sweep_done = 1'b0; rd_addr = '0; rd_chk = 1'b0;
      idle(2);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_cnt", 64'(sweep_cnt), 64'(0));
      check("rst_ovr", 64'(ovr), 64'(0));
      check("rst_rd", 64'(rd_data), 64'(0));
      rst = 1'b0;
      tick();

      // Run A: K=2 clear, readback of zeros, 4-sweep average, strays in DONE.
      do_start(4'd2);
      for (int i = 0; i < 256; i++) begin
         check("clear_busy", 64'(busy), 64'(1));
         tick();
      end
      for (int i = 0; i < 512; i++) rd_lit("clear_zero", 9'(i), 32'h0);
      strobe(8'd5, 32'd10, 32'hFFFF_FFF8, 1'b0); idle(2); sweep_end();
      strobe(8'd5, 32'd20, 32'hFFFF_FFFC, 1'b0); idle(2); sweep_end();
      strobe(8'd5, 32'd30, 32'h0000_0000, 1'b0); idle(2); sweep_end();
      check("avg_busy_run", 64'(busy), 64'(1));
      strobe(8'd5, 32'd44, 32'hFFFF_FFFC, 1'b1);
      idle(2);
      check("avg_done", 64'(done), 64'(1));
      check("avg_busy_off", 64'(busy), 64'(0));
      check("avg_cnt", 64'(sweep_cnt), 64'(4));
      check("avg_ovr_clean", 64'(ovr), 64'(0));
      rd_lit("avg_mag", 9'h005, 32'd26);
      rd_lit("avg_phs", 9'h105, 32'hFFFF_FFFC);
      strobe(8'd5, 32'd500, 32'd77, 1'b1);
      idle(3);
      check("done_stray_ovr", 64'(ovr), 64'(1));
      check("done_stray_cnt", 64'(sweep_cnt), 64'(4));
      rd_lit("done_stray_mag", 9'h005, 32'd26);

      // Run B: K=0, stray in last CLEAR cycle, back-to-back hazard on addr 7.
      do_start(4'd0);
      check("start_ovr_clr", 64'(ovr), 64'(0));
      idle(255);
      strobe(8'd9, 32'd1000, 32'd1000, 1'b0);
      check("clear_stray_ovr", 64'(ovr), 64'(1));
      strobe(8'd7, 32'd1, 32'd5, 1'b0);
      strobe(8'd7, 32'd2, 32'hFFFF_FFFE, 1'b0);
      strobe(8'd7, 32'd3, 32'hFFFF_FFF9, 1'b0);
      sweep_end();
      idle(2);
      check("haz_done", 64'(done), 64'(1));
      rd_lit("haz_mag", 9'h007, 32'd6);
      rd_lit("haz_phs", 9'h107, 32'hFFFF_FFFC);
      rd_lit("clear_stray_ram", 9'h009, 32'd0);

      // Run C: K=1, abort one cycle after a strobe loses that write.
      do_start(4'd1);
      idle(256);
      strobe(8'd21, 32'd5, 32'd6, 1'b0);
      idle(3);
      strobe(8'd20, 32'd7, 32'd7, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      idle(3);
      rd_lit("abort_lost", 9'h014, 32'd0);
      rd_lit("abort_kept_mag", 9'h015, 32'd2);
      rd_lit("abort_kept_phs", 9'h115, 32'd3);

      // Run D: K requested 12 clamps to 8; 256 sweeps of full-scale magnitude.
      do_start(4'd12);
      idle(256);
      for (int i = 0; i < 255; i++) begin
         strobe(8'd255, 32'hFFFF_FFFF, 32'h0, 1'b0);
         sweep_end();
      end
      idle(2);
      check("clamp_not_done", 64'(done), 64'(0));
      check("clamp_cnt255", 64'(sweep_cnt), 64'(255));
      strobe(8'd255, 32'hFFFF_FFFF, 32'h0, 1'b0);
      sweep_end();
      idle(2);
      check("clamp_done", 64'(done), 64'(1));
      check("clamp_cnt256", 64'(sweep_cnt), 64'(256));
      rd_lit("clamp_mag", 9'h0FF, 32'hFFFF_FFFF);

      // Run E: reset during RUN zeroes every output.
      do_start(4'd3);
      strobe(8'd1, 32'd1, 32'd1, 1'b0);
      idle(256);
      strobe(8'd2, 32'd8, 32'd8, 1'b0);
      sweep_end();
      rst = 1'b1;
      tick();
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_cnt", 64'(sweep_cnt), 64'(0));
      check("midrst_ovr", 64'(ovr), 64'(0));
      check("midrst_rd", 64'(rd_data), 64'(0));
      rst = 1'b0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sweep_result_avg.md
SWEEP_RESULT_AVG -- requirements
Module: sweep_result_avg

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, frequency-point address width (256 points).
REQ-002 Parameter DATA_WIDTH, default 32, width of magnitude and phase result words.
REQ-003 Parameter GUARD, default 8, accumulator guard bits; accumulator width ACC_W = DATA_WIDTH+GUARD.
REQ-004 dac_clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 dac_rst_i  input  1  reset; synchronous, active-high.
REQ-006 start_i  input  1  one-cycle pulse; begins a clear-then-average run.
REQ-007 abort_i  input  1  one-cycle pulse; abandons the run.
REQ-008 avg_log2_i  input  4  number of sweeps to average = 2^avg_log2_i; values above 8 are treated as 8.
REQ-009 res_we_i  input  1  one-cycle strobe marking one point result from the chirp control path.
REQ-010 res_addr_i  input  ADDR_WIDTH  point index of the strobed result.
REQ-011 res_mag_i  input  DATA_WIDTH  unsigned magnitude.
REQ-012 res_phs_i  input  DATA_WIDTH  two's-complement phase.
REQ-013 sweep_done_i  input  1  one-cycle pulse at the end of each sweep.
REQ-014 rd_addr_i  input  ADDR_WIDTH+1  readback address; MSB 0 selects magnitude, MSB 1 selects phase.
REQ-015 rd_data_o  output  DATA_WIDTH  readback data.
REQ-016 busy_o  output  1  high in CLEAR and RUN.
REQ-017 done_o  output  1  high in DONE.
REQ-018 sweep_cnt_o  output  9  sweeps completed in the current run.
REQ-019 ovr_o  output  1  sticky flag; a result strobe arrived outside RUN.

Function
REQ-020 The state machine SHALL have four states: IDLE, CLEAR, RUN and DONE.
REQ-021 On start_i in any state, the block SHALL latch the clamped avg_log2_i as K, zero sweep_cnt_o and ovr_o, and enter CLEAR.
REQ-022 CLEAR SHALL write zero to both accumulators at one address per cycle, from address 0 to 255, then enter RUN. CLEAR lasts exactly 256 cycles.
REQ-023 In RUN, each res_we_i SHALL add res_mag_i (zero-extended) and res_phs_i (sign-extended) to the accumulators at res_addr_i.
REQ-024 Each accumulate SHALL be a 3-stage read-modify-write:
- cycle 0: capture the strobe;
- cycle 1: read the accumulator;
- cycle 2: write the sum.
REQ-025 A strobe to an address whose write is still pending in cycle 1 or cycle 2 SHALL use the forwarded pending sum, so back-to-back strobes to the same address both accumulate.
REQ-026 At most one strobe per cycle is accepted; there SHALL be no backpressure and no strobe is dropped in RUN.
REQ-027 Accumulator additions SHALL wrap modulo 2^ACC_W; with GUARD=8 and K≤8, overflow cannot occur.
REQ-028 sweep_done_i in RUN SHALL increment sweep_cnt_o.
REQ-029 A strobe in the same cycle as sweep_done_i SHALL belong to the sweep that is ending.
REQ-030 When sweep_cnt_o reaches 2^K, the block SHALL wait until the pipeline is empty, then enter DONE. This happens no later than 2 cycles after the final sweep_done_i.
REQ-031 In DONE, further res_we_i and sweep_done_i SHALL NOT modify the accumulators or the count; res_we_i SHALL set ovr_o.
REQ-032 res_we_i in IDLE or CLEAR SHALL be ignored and SHALL set ovr_o.
REQ-033 abort_i SHALL enter IDLE next cycle, discard in-flight pipeline writes and leave accumulator contents as they are. If abort_i and start_i arrive in the same cycle, start_i wins.
REQ-034 Readback SHALL have 1-cycle latency in every state.
REQ-035 rd_data_o SHALL equal the selected accumulator shifted right by K, truncated to DATA_WIDTH:
- magnitude uses a logical shift;
- phase uses an arithmetic shift.
REQ-036 During RUN, readback SHALL return partial averages; a read of an address being written in the same cycle returns the old value.
REQ-037 The accumulators SHALL be single-clock RAM with one read port for read-modify-write and one read port for readback.

Reset
REQ-038 On dac_rst_i, the state SHALL be IDLE, and K, sweep_cnt_o, ovr_o, busy_o, done_o, rd_data_o and all pipeline valids SHALL be 0.
REQ-039 Reset SHALL NOT clear RAM contents; RAM is defined only after a CLEAR.
REQ-040 Reset asserted mid-run SHALL override all other inputs and cancel pending writes.

Verification
REQ-041 Clear: avg_log2_i=2, start_i -> busy_o high for 256 cycles of CLEAR; a read of every address returns 0.
REQ-042 Average: K=2, 4 sweeps each writing addr 5 with mag {10,20,30,44} and phs {-8,-4,0,-4} -> done_o rises ≤2 cycles after the 4th sweep_done_i; rd_addr 0x005 returns 26; rd_addr 0x105 returns -4 (0xFFFFFFFC).
REQ-043 Hazard: K=0, res_we_i on 3 consecutive cycles to addr 7 with mag 1, 2, 3, then sweep_done_i -> addr 7 reads 6.
REQ-044 Boundary: K requested 12 -> clamped to 8, so done_o only after 256 sweeps. Mag 0xFFFFFFFF at addr 255 in every sweep -> reads 0xFFFFFFFF, with no wrap.
REQ-045 Stray strobes: res_we_i during CLEAR and during DONE -> ovr_o=1; RAM unchanged; sweep_cnt_o unchanged.
REQ-046 Abort/reset: abort_i one cycle after a strobe -> that write is lost and the state is IDLE. dac_rst_i in RUN -> all outputs 0 on the next cycle.
